// File: rtl/ibex_load_resp_unit_if.sv
// Request-attribute, data-bus response and writeback-side signals of the load/store response unit.
// The DUT binds the slave modport and the request/bus driver binds the master modport.
interface ibex_load_resp_unit_if;
  logic        req_issue_i;
  logic        req_we_i;
  logic [1:0]  req_type_i;
  logic        req_sign_ext_i;
  logic [1:0]  req_offset_i;
  logic        req_fp_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;
  logic        ready_o;
  logic        busy_o;
  logic [31:0] rf_wdata_lsu_o;
  logic        rf_we_lsu_o;
  logic        lsu_resp_valid_o;
  logic        lsu_resp_err_o;
  logic        fp_load_o;

  modport slave (
    input  req_issue_i, req_we_i, req_type_i, req_sign_ext_i, req_offset_i, req_fp_i,
    input  data_rvalid_i, data_rdata_i, data_err_i,
    output ready_o, busy_o, rf_wdata_lsu_o, rf_we_lsu_o, lsu_resp_valid_o,
    output lsu_resp_err_o, fp_load_o
  );

  modport master (
    output req_issue_i, req_we_i, req_type_i, req_sign_ext_i, req_offset_i, req_fp_i,
    output data_rvalid_i, data_rdata_i, data_err_i,
    input  ready_o, busy_o, rf_wdata_lsu_o, rf_we_lsu_o, lsu_resp_valid_o,
    input  lsu_resp_err_o, fp_load_o
  );
endinterface

// File: rtl/ibex_load_resp_unit.sv
// Collects one or two bus responses per data access, recombines split beats and
// presents the aligned/extended load result to writeback in the final-response cycle.
//
// state  | meaning
// IDLE   | no access outstanding
// WAIT_1 | first or only response pending
// WAIT_2 | second beat of a split access pending, first beat held in rdata_q
module ibex_load_resp_unit #(
  parameter int unsigned FPU_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ibex_load_resp_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_1 = 2'd1,
    WAIT_2 = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 we_q;
  logic [1:0]           type_q;
  logic                 sign_ext_q;
  logic [1:0]           offset_q;
  logic                 fp_q;
  logic                 split_q;
  logic                 err_q;
  logic [FPU_WIDTH-1:0] rdata_q;

  logic        accept;
  logic        final_resp;
  logic        first_of_split;
  logic        split_new;
  logic        resp_err;
  logic [31:0] shifted;
  logic [31:0] aligned;

  assign final_resp     = bus.data_rvalid_i &
                          (((state_q == WAIT_1) & ~split_q) | (state_q == WAIT_2));
  assign first_of_split = bus.data_rvalid_i & (state_q == WAIT_1) & split_q;
  assign accept         = bus.req_issue_i & bus.ready_o;

  // Type 2'b11 falls into the word case.
  assign split_new = ((bus.req_type_i != 2'b01) & (bus.req_type_i != 2'b10) &
                      (bus.req_offset_i != 2'b00)) |
                     ((bus.req_type_i == 2'b01) & (bus.req_offset_i == 2'b11));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_issue_i) state_d = WAIT_1;
      end
      WAIT_1: begin
        if (first_of_split) state_d = WAIT_2;
        else if (final_resp) state_d = bus.req_issue_i ? WAIT_1 : IDLE;
      end
      WAIT_2: begin
        if (final_resp) state_d = bus.req_issue_i ? WAIT_1 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      type_q     <= 2'b00;
      sign_ext_q <= 1'b0;
      offset_q   <= 2'b00;
      fp_q       <= 1'b0;
      split_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q       <= bus.req_we_i;
        type_q     <= bus.req_type_i;
        sign_ext_q <= bus.req_sign_ext_i;
        offset_q   <= bus.req_offset_i;
        fp_q       <= bus.req_fp_i;
        split_q    <= split_new;
        err_q      <= 1'b0;
      end else if (first_of_split) begin
        rdata_q <= bus.data_rdata_i;
        err_q   <= err_q | bus.data_err_i;
      end
    end
  end

  // Split beats carry the low bytes in rdata_q and the high bytes in the current beat.
  always_comb begin
    shifted = bus.data_rdata_i >> {offset_q, 3'b000};
    aligned = 32'h0;
    case (type_q)
      2'b01: begin
        if (offset_q == 2'b11) aligned[15:0] = {bus.data_rdata_i[7:0], rdata_q[31:24]};
        else                   aligned[15:0] = shifted[15:0];
        aligned[31:16] = {16{sign_ext_q & aligned[15]}};
      end
      2'b10: begin
        aligned[7:0]  = shifted[7:0];
        aligned[31:8] = {24{sign_ext_q & aligned[7]}};
      end
      default: begin
        case (offset_q)
          2'b01:   aligned = {bus.data_rdata_i[7:0],  rdata_q[31:8]};
          2'b10:   aligned = {bus.data_rdata_i[15:0], rdata_q[31:16]};
          2'b11:   aligned = {bus.data_rdata_i[23:0], rdata_q[31:24]};
          default: aligned = bus.data_rdata_i;
        endcase
      end
    endcase
  end

  assign resp_err = final_resp & (err_q | bus.data_err_i);

  assign bus.ready_o          = (state_q == IDLE) | final_resp;
  assign bus.busy_o           = (state_q != IDLE);
  assign bus.lsu_resp_valid_o = final_resp;
  assign bus.lsu_resp_err_o   = resp_err;
  assign bus.rf_we_lsu_o      = final_resp & ~we_q & ~resp_err;
  assign bus.rf_wdata_lsu_o   = (final_resp & ~we_q) ? aligned : 32'h0;
  assign bus.fp_load_o        = fp_q & bus.busy_o;

endmodule

// File: tb/tb_ibex_load_resp_unit.sv
// Directed scenarios followed by random traffic, checked cycle by cycle against an
// access-level reference model of the response unit.
module tb_ibex_load_resp_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_load_resp_unit_if bus_if ();

  ibex_load_resp_unit #(.FPU_WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one outstanding access, described by its attributes and beat count.
  bit        m_busy;
  bit        m_we, m_sext, m_fp, m_split, m_err;
  bit [1:0]  m_type, m_off;
  int        m_beats_seen;
  bit [31:0] m_q;

  logic [31:0] o_wdata;
  logic        o_we, o_valid, o_err, o_fp, o_ready, o_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit [31:0] ref_load(input bit [1:0] typ, input bit sext,
                                         input bit [1:0] off, input bit split,
                                         input bit [31:0] d, input bit [31:0] q);
    bit [63:0] both;
    bit [31:0] v;
    int        nbytes;
    both   = split ? {d, q} : {32'h0, d};
    both   = both >> (8 * off);
    v      = both[31:0];
    nbytes = (typ == 2'b01) ? 2 : (typ == 2'b10) ? 1 : 4;
    if (nbytes == 2) begin
      v = v & 32'h0000_FFFF;
      if (sext && v[15]) v = v | 32'hFFFF_0000;
    end else if (nbytes == 1) begin
      v = v & 32'h0000_00FF;
      if (sext && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_we = 0; m_sext = 0; m_fp = 0; m_split = 0; m_err = 0;
    m_type = 0; m_off = 0; m_beats_seen = 0; m_q = 0;
  endtask

  task automatic cycle(input bit issue, input bit we, input bit [1:0] typ, input bit sext,
                       input bit [1:0] off, input bit fp, input bit rvalid,
                       input bit [31:0] rdata, input bit err);
    bit        fin, e_ready, e_err, e_we;
    bit [31:0] e_wdata;
    @(posedge clk);
    #1;
    bus_if.req_issue_i    = issue;
    bus_if.req_we_i       = we;
    bus_if.req_type_i     = typ;
    bus_if.req_sign_ext_i = sext;
    bus_if.req_offset_i   = off;
    bus_if.req_fp_i       = fp;
    bus_if.data_rvalid_i  = rvalid;
    bus_if.data_rdata_i   = rdata;
    bus_if.data_err_i     = err;
    #3;
    fin     = m_busy && rvalid && (!m_split || m_beats_seen == 1);
    e_ready = !m_busy || fin;
    e_err   = fin && (m_err || err);
    e_we    = fin && !m_we && !e_err;
    e_wdata = (fin && !m_we) ? ref_load(m_type, m_sext, m_off, m_split, rdata, m_q) : 32'h0;
    o_wdata = bus_if.rf_wdata_lsu_o;
    o_we    = bus_if.rf_we_lsu_o;
    o_valid = bus_if.lsu_resp_valid_o;
    o_err   = bus_if.lsu_resp_err_o;
    o_fp    = bus_if.fp_load_o;
    o_ready = bus_if.ready_o;
    o_busy  = bus_if.busy_o;
    chk("ready", {31'b0, o_ready}, {31'b0, e_ready});
    chk("busy", {31'b0, o_busy}, {31'b0, m_busy});
    chk("resp_valid", {31'b0, o_valid}, {31'b0, fin});
    chk("resp_err", {31'b0, o_err}, {31'b0, e_err});
    chk("rf_we", {31'b0, o_we}, {31'b0, e_we});
    chk("fp_load", {31'b0, o_fp}, {31'b0, m_fp && m_busy});
    if (!e_err) chk("rf_wdata", o_wdata, e_wdata);
    // Advance the model to the state after the coming clock edge.
    if (m_busy && rvalid) begin
      if (fin) m_busy = 0;
      else begin
        m_beats_seen = 1;
        m_q          = rdata;
        m_err        = m_err || err;
      end
    end
    if (issue && e_ready) begin
      m_busy = 1; m_we = we; m_type = typ; m_sext = sext; m_off = off; m_fp = fp;
      m_split = ((typ != 2'b01 && typ != 2'b10) && off != 0) || (typ == 2'b01 && off == 3);
      m_err = 0; m_beats_seen = 0;
    end
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 2'b00, 0, 2'b00, 0, 0, 32'h0, 0);
  endtask

  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    bus_if.req_issue_i   = 0;
    bus_if.data_rvalid_i = 0;
    #1;
    model_reset();
    chk("rst_busy", {31'b0, bus_if.busy_o}, 32'd0);
    chk("rst_ready", {31'b0, bus_if.ready_o}, 32'd1);
    chk("rst_valid", {31'b0, bus_if.lsu_resp_valid_o}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bus_if.req_issue_i = 0; bus_if.req_we_i = 0; bus_if.req_type_i = 0;
    bus_if.req_sign_ext_i = 0; bus_if.req_offset_i = 0; bus_if.req_fp_i = 0;
    bus_if.data_rvalid_i = 0; bus_if.data_rdata_i = 0; bus_if.data_err_i = 0;
    model_reset();
    #12;
    chk("reset_ready", {31'b0, bus_if.ready_o}, 32'd1);
    chk("reset_busy", {31'b0, bus_if.busy_o}, 32'd0);
    chk("reset_wdata", bus_if.rf_wdata_lsu_o, 32'h0);
    rst_n = 1'b1;

    // Aligned word load.
    cycle(1, 0, 2'b00, 0, 2'd0, 0, 0, 32'h0, 0);
    cycle(0, 0, 2'b00, 0, 2'd0, 0, 1, 32'hDEADBEEF, 0);
    chk("word_wdata", o_wdata, 32'hDEADBEEF);
    chk("word_we", {31'b0, o_we}, 32'd1);

    // Byte offset 2, sign- then zero-extended.
    cycle(1, 0, 2'b10, 1, 2'd2, 0, 0, 32'h0, 0);
    cycle(0, 0, 2'b00, 0, 2'd0, 0, 1, 32'h0080_0000, 0);
    chk("byte_sext", o_wdata, 32'hFFFFFF80);
    cycle(1, 0, 2'b10, 0, 2'd2, 0, 0, 32'h0, 0);
    cycle(0, 0, 2'b00, 0, 2'd0, 0, 1, 32'h0080_0000, 0);
    chk("byte_zext", o_wdata, 32'h00000080);

    // Misaligned word, offset 1.
    cycle(1, 0, 2'b00, 0, 2'd1, 0, 0, 32'h0, 0);
    cycle(0, 0, 2'b00, 0, 2'd0, 0, 1, 32'h44332211, 0);
    chk("split_beat1_valid", {31'b0, o_valid}, 32'd0);
    cycle(0, 0, 2'b00, 0, 2'd0, 0, 1, 32'h88776655, 0);
    chk("split_wdata", o_wdata, 32'h55443322);
    chk("split_valid", {31'b0, o_valid}, 32'd1);
    idle_cycle();
    chk("split_single_pulse", {31'b0, o_valid}, 32'd0);

    // Split half offset 3 with a sticky beat-1 error.
    cycle(1, 0, 2'b01, 1, 2'd3, 0, 0, 32'h0, 0);
    cycle(0, 0, 2'b00, 0, 2'd0, 0, 1, 32'hAA000000, 1);
    chk("err_beat1_silent", {31'b0, o_err}, 32'd0);
    cycle(0, 0, 2'b00, 0, 2'd0, 0, 1, 32'h000000BB, 0);
    chk("err_sticky", {31'b0, o_err}, 32'd1);
    chk("err_no_we", {31'b0, o_we}, 32'd0);

    // Store completing while an FP word load is accepted.
    cycle(1, 1, 2'b00, 0, 2'd0, 0, 0, 32'h0, 0);
    cycle(1, 0, 2'b00, 0, 2'd0, 1, 1, 32'h0, 0);
    chk("store_valid", {31'b0, o_valid}, 32'd1);
    chk("store_no_we", {31'b0, o_we}, 32'd0);
    chk("b2b_ready", {31'b0, o_ready}, 32'd1);
    cycle(0, 0, 2'b00, 0, 2'd0, 0, 1, 32'h12345678, 0);
    chk("fp_flag", {31'b0, o_fp}, 32'd1);
    chk("fp_we", {31'b0, o_we}, 32'd1);

    // Reset while waiting on beat 2, then a stray response.
    cycle(1, 0, 2'b00, 0, 2'd2, 0, 0, 32'h0, 0);
    cycle(0, 0, 2'b00, 0, 2'd0, 0, 1, 32'h11111111, 0);
    async_reset();
    cycle(0, 0, 2'b00, 0, 2'd0, 0, 1, 32'h22222222, 0);
    chk("stray_valid", {31'b0, o_valid}, 32'd0);
    chk("stray_wdata", o_wdata, 32'h0);

    // Random traffic, including ignored issues and stray responses.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, $urandom(),
            $urandom_range(0, 7) == 0);
      if (i == 1500) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ibex_load_resp_unit.md
# ibex_load_resp_unit

Load/store response unit between the data bus and the writeback stage. It latches the attributes of each accepted data request and collects the one or two bus responses for that request. Misaligned accesses are split into two beats, and the unit recombines them. It aligns, sign- or zero-extends and routes load data, and presents `rf_wdata_lsu`, `rf_we_lsu`, `lsu_resp_valid`, `lsu_resp_err` and the FP-load flag to the writeback stage in the cycle the final response arrives.

## Interface
- `FPU_WIDTH`, 32: width of the FP load data path. Only 32 is supported; FP loads use the word path.
- `clk_i` input 1: clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `req_issue_i` input 1: first data request of a new access granted on the bus this cycle. Sampled only when `ready_o`=1.
- `req_we_i` input 1: access is a store.
- `req_type_i` input 2: 2'b00 word, 2'b01 half, 2'b10 byte; 2'b11 is treated as word.
- `req_sign_ext_i` input 1: sign-extend half/byte loads.
- `req_offset_i` input 2: byte offset `addr[1:0]`.
- `req_fp_i` input 1: load targets the FP register file.
- `data_rvalid_i` input 1: bus response valid.
- `data_rdata_i` input 32: bus read data.
- `data_err_i` input 1: bus error, qualified by `data_rvalid_i`.
- `ready_o` output 1: a new access can be accepted this cycle.
- `busy_o` output 1: an access is outstanding.
- `rf_wdata_lsu_o` output 32: aligned/extended load result.
- `rf_we_lsu_o` output 1: load result valid for RF write.
- `lsu_resp_valid_o` output 1: access complete; one pulse per access.
- `lsu_resp_err_o` output 1: access completed with error.
- `fp_load_o` output 1: latched `req_fp_i` of the current access.

## Operation
- The FSM has three states:
  - IDLE: no access outstanding.
  - WAIT_1: first or only response pending.
  - WAIT_2: second response of a split access pending; the first beat is held in `rdata_q`.
- Split is computed at accept time: `split = (word & offset!=0) | (half & offset==3)`.
- Attributes are latched on accept: `we`, `type`, `sign_ext`, `offset`, `fp`, `split`. The error flag `err_q` is cleared.
- Transitions:
  - IDLE to WAIT_1 on `req_issue_i`.
  - WAIT_1 with `data_rvalid_i`:
    - if `split`, go to WAIT_2, capture `rdata_q`, set `err_q |= data_err_i`;
    - otherwise the access is final.
  - WAIT_2 with `data_rvalid_i`: the access is final.
  - Final response: go to IDLE, or to WAIT_1 if `req_issue_i` is accepted in the same cycle.
- `ready_o` = IDLE | final response this cycle.
- `data_rvalid_i` in IDLE is ignored and produces no outputs.
- Upstream guarantees that the second bus request of a split access is issued. This unit only counts responses.
- Final-response outputs are combinational from `data_rvalid_i`:
  - `lsu_resp_valid_o`=1;
  - `lsu_resp_err_o` = `err_q | data_err_i`;
  - `rf_we_lsu_o` = `~we & ~lsu_resp_err_o`.
- All outputs are 0 when there is no final response, except `fp_load_o`, `busy_o` and `ready_o`.
- Alignment (D = current beat, Q = `rdata_q`):
  - word, offset 0: D.
  - word, offset 1: {D[7:0], Q[31:8]}.
  - word, offset 2: {D[15:0], Q[31:16]}.
  - word, offset 3: {D[23:0], Q[31:24]}.
  - half, offset 0/1/2: (D >> 8*offset)[15:0]; offset 3: {D[7:0], Q[31:24]}.
  - byte: (D >> 8*offset)[7:0].
  - Half/byte results are extended to 32 bits with bit 15/7 when `sign_ext`, else with zeros.
- For stores, `rf_wdata_lsu_o` is don't-care and driven as 0.
- `fp_load_o` = `fp_q & busy_o`. It is valid in the completion cycle, so the writeback stage steers the write to the FP RF.

## Timing
- Reset values:
  - state IDLE;
  - `err_q`=0, `rdata_q`=0;
  - `ready_o`=1, `busy_o`=0;
  - all response outputs 0.
- Reset mid-access drops the access with no response pulse.
- Latency, aligned access: response output in the same cycle as `data_rvalid_i`. Earliest is the cycle after accept.
- Latency, split access: output in the cycle of the second `data_rvalid_i`. The first beat produces no output.
- An error on beat 1 of a split is sticky. It is reported only on beat 2, and the RF write is suppressed.
- Back-to-back: completion and accept in the same cycle are both honoured. The new attributes take effect from the next cycle. The completing access's outputs use the old attributes.
- No more than one access is ever outstanding.

## Test plan
- Aligned word load, `rdata`=0xDEADBEEF, offset 0 -> one cycle later `rf_we`=1, `wdata`=0xDEADBEEF, `resp_valid`=1, `err`=0.
- Byte load, offset 2, sign_ext, `rdata`=0x0080_0000 -> `wdata`=0xFFFFFF80. Repeat with zero-ext -> 0x00000080.
- Misaligned word, offset 1, beats 0x44332211 then 0x88776655 -> no output on beat 1; on beat 2 `wdata`=0x55443322 and a single `resp_valid` pulse.
- Split half, offset 3, beat-1 `err`=1, beat-2 `err`=0 -> on beat 2 `resp_valid`=1, `err`=1, `rf_we`=0.
- Store completion with `req_issue_i` in the same cycle, then FP load word -> store gives `resp_valid`=1 with `rf_we`=0; the next response has `fp_load_o`=1 and `rf_we`=1; `ready_o` stays 1 at the completion edge.
- Reset asserted in WAIT_2 -> state IDLE, `busy_o`=0; a later stray `data_rvalid_i` is ignored with no output.
